// File: rtl/core_pkg.sv
// Shared RV32I core constants: ALU opcodes, branch encodings and datapath widths.
// Imported by the ID/EX stage, its interface and the forwarding select.
package core_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_JAL  = 3'b101;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decoded instruction in, ALU/EX-MEM operands out.
// master = decode side, slave = the ID/EX stage.
interface id_ex_stage_if #(
  parameter int XLEN   = core_pkg::XLEN_DEFAULT,
  parameter int REG_AW = core_pkg::REG_AW_DEFAULT
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [3:0]        id_alu_sel;
  logic              id_use_imm;
  logic              id_use_pc;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic [2:0]        id_branch;

  logic              load_use_stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_op_a;
  logic [XLEN-1:0]   ex_op_b;
  logic [3:0]        ex_alu_sel;
  logic [XLEN-1:0]   ex_store_data;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [2:0]        ex_branch;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_sel, id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write,
           id_branch,
    input  load_use_stall, ex_valid, ex_op_a, ex_op_b, ex_alu_sel, ex_store_data, ex_pc,
           ex_imm, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_sel, id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write,
           id_branch,
    output load_use_stall, ex_valid, ex_op_a, ex_op_b, ex_alu_sel, ex_store_data, ex_pc,
           ex_imm, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch
  );
endinterface

// File: rtl/ex_fwd_sel.sv
// Combinational 3:1 operand forwarding select for one EX source register.
// EX/MEM has priority over MEM/WB; x0 is never forwarded.
module ex_fwd_sel
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rs_data,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   fwd_data
);
  always_comb begin
    fwd_data = rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
      fwd_data = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
      fwd_data = memwb_result;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use bubble insertion.
// Define ID_EX_FWD_EN for forwarding; without it operands are unforwarded and every RAW hazard stalls.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_result,
  id_ex_stage_if.slave      bus
);
`ifdef ID_EX_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic              use_imm_q, use_imm_d;
  logic              use_pc_q, use_pc_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [2:0]        branch_q, branch_d;

  logic              load_hit;
  logic              load_use_stall;

  // True when an older in-flight writer has not yet reached WB for this source.
  function automatic logic raw_hit(input logic [REG_AW-1:0] rs);
    return (rs != '0) &&
           ((valid_q && reg_write_q && (rd_q == rs)) ||
            (exmem_reg_write && (exmem_rd == rs)));
  endfunction

  always_comb begin
    load_hit = valid_q && mem_read_q && (rd_q != '0) && bus.id_valid &&
               ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2));
    if (FWD_ON) begin
      load_use_stall = load_hit;
    end else begin
      load_use_stall = load_hit ||
                       (bus.id_valid && (raw_hit(bus.id_rs1) || raw_hit(bus.id_rs2)));
    end
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_sel_d   = alu_sel_q;
    use_imm_d   = use_imm_q;
    use_pc_d    = use_pc_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    branch_d    = branch_q;
    // flush beats hold; hold beats the load-use bubble.
    if (flush || (!hold && load_use_stall)) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      alu_sel_d   = ALU_ADD;
      use_imm_d   = 1'b0;
      use_pc_d    = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = BR_NONE;
    end else if (!hold) begin
      valid_d     = bus.id_valid;
      pc_d        = bus.id_pc;
      rs1_data_d  = bus.id_rs1_data;
      rs2_data_d  = bus.id_rs2_data;
      imm_d       = bus.id_imm;
      rs1_d       = bus.id_rs1;
      rs2_d       = bus.id_rs2;
      rd_d        = bus.id_rd;
      alu_sel_d   = bus.id_alu_sel;
      use_imm_d   = bus.id_use_imm;
      use_pc_d    = bus.id_use_pc;
      reg_write_d = bus.id_valid && bus.id_reg_write;
      mem_read_d  = bus.id_valid && bus.id_mem_read;
      mem_write_d = bus.id_valid && bus.id_mem_write;
      branch_d    = bus.id_valid ? bus.id_branch : BR_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_sel_q   <= ALU_ADD;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= BR_NONE;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_sel_q   <= alu_sel_d;
      use_imm_q   <= use_imm_d;
      use_pc_q    <= use_pc_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
    end
  end

  logic [REG_AW-1:0] src_idx  [2];
  logic [XLEN-1:0]   src_data [2];
  logic [XLEN-1:0]   fwd_data [2];

  assign src_idx[0]  = rs1_q;
  assign src_idx[1]  = rs2_q;
  assign src_data[0] = rs1_data_q;
  assign src_data[1] = rs2_data_q;

  // With forwarding disabled the write enables are tied off, so each select passes rs data through.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      ex_fwd_sel #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
      ) u_fwd_sel (
        .rs              (src_idx[gi]),
        .rs_data         (src_data[gi]),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write && FWD_ON),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write && FWD_ON),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_data[gi])
      );
    end
  endgenerate

  assign bus.load_use_stall = load_use_stall;
  assign bus.ex_valid       = valid_q;
  assign bus.ex_op_a        = use_pc_q ? pc_q : fwd_data[0];
  assign bus.ex_op_b        = use_imm_q ? imm_q : fwd_data[1];
  assign bus.ex_store_data  = fwd_data[1];
  assign bus.ex_alu_sel     = alu_sel_q;
  assign bus.ex_pc          = pc_q;
  assign bus.ex_imm         = imm_q;
  assign bus.ex_rd          = rd_q;
  assign bus.ex_reg_write   = reg_write_q;
  assign bus.ex_mem_read    = mem_read_q;
  assign bus.ex_mem_write   = mem_write_q;
  assign bus.ex_branch      = branch_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized traffic
// compared each cycle against an instruction-level reference model.
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int XW = XLEN_DEFAULT;
  localparam int RW = REG_AW_DEFAULT;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold;
  logic          flush;
  logic [RW-1:0] exmem_rd;
  logic          exmem_reg_write;
  logic [XW-1:0] exmem_result;
  logic [RW-1:0] memwb_rd;
  logic          memwb_reg_write;
  logic [XW-1:0] memwb_result;

  id_ex_stage_if #(.XLEN(XW), .REG_AW(RW)) bus ();

  id_ex_stage #(.XLEN(XW), .REG_AW(RW)) dut (
    .clk             (clk),
    .rst             (rst),
    .hold            (hold),
    .flush           (flush),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [XW-1:0] pc, d1, d2, imm;
    logic [RW-1:0] rs1, rs2, rd;
    logic [3:0]    alu;
    logic          ui, up, rw, mr, mw;
    logic [2:0]    br;
  } instr_t;

  instr_t m;
  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t empty_slot();
    instr_t z;
    z = '{default: '0};
    return z;
  endfunction

  // Value the ALU sees for a source: youngest in-flight writer wins, register file otherwise.
  function automatic logic [XW-1:0] operand(input logic [RW-1:0] idx, input logic [XW-1:0] rf);
`ifdef ID_EX_FWD_EN
    if (idx != '0 && exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (idx != '0 && memwb_reg_write && memwb_rd == idx) return memwb_result;
`endif
    return rf;
  endfunction

  function automatic logic exp_stall();
    logic [RW-1:0] srcs [2];
    logic hit;
    if (!bus.id_valid) return 1'b0;
    srcs[0] = bus.id_rs1;
    srcs[1] = bus.id_rs2;
    hit = 1'b0;
    foreach (srcs[k]) begin
      if (srcs[k] != '0 && m.v && m.mr && m.rd == srcs[k]) hit = 1'b1;
`ifndef ID_EX_FWD_EN
      if (srcs[k] != '0 && m.v && m.rw && m.rd == srcs[k]) hit = 1'b1;
      if (srcs[k] != '0 && exmem_reg_write && exmem_rd == srcs[k]) hit = 1'b1;
`endif
    end
    return hit;
  endfunction

  function automatic instr_t next_state();
    instr_t n;
    if (flush) return empty_slot();
    if (hold) return m;
    if (exp_stall()) return empty_slot();
    n.v   = bus.id_valid;
    n.pc  = bus.id_pc;
    n.d1  = bus.id_rs1_data;
    n.d2  = bus.id_rs2_data;
    n.imm = bus.id_imm;
    n.rs1 = bus.id_rs1;
    n.rs2 = bus.id_rs2;
    n.rd  = bus.id_rd;
    n.alu = bus.id_alu_sel;
    n.ui  = bus.id_use_imm;
    n.up  = bus.id_use_pc;
    n.rw  = bus.id_valid && bus.id_reg_write;
    n.mr  = bus.id_valid && bus.id_mem_read;
    n.mw  = bus.id_valid && bus.id_mem_write;
    n.br  = bus.id_valid ? bus.id_branch : BR_NONE;
    return n;
  endfunction

  task automatic check_outputs();
    check_eq("stall", 32'(bus.load_use_stall), 32'(exp_stall()));
    check_eq("valid", 32'(bus.ex_valid), 32'(m.v));
    check_eq("op_a", bus.ex_op_a, m.up ? m.pc : operand(m.rs1, m.d1));
    check_eq("op_b", bus.ex_op_b, m.ui ? m.imm : operand(m.rs2, m.d2));
    check_eq("store_data", bus.ex_store_data, operand(m.rs2, m.d2));
    check_eq("alu_sel", 32'(bus.ex_alu_sel), 32'(m.alu));
    check_eq("pc", bus.ex_pc, m.pc);
    check_eq("imm", bus.ex_imm, m.imm);
    check_eq("rd", 32'(bus.ex_rd), 32'(m.rd));
    check_eq("reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
    check_eq("mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
    check_eq("mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
    check_eq("branch", 32'(bus.ex_branch), 32'(m.br));
  endtask

  // Called at the falling edge with inputs applied; checks, then advances one clock.
  task automatic step();
    instr_t nxt;
    #1;
    check_outputs();
    $display("txn %0d: hold=%0b flush=%0b stall=%0b ex_valid=%0b op_a=%h op_b=%h",
             txn, hold, flush, bus.load_use_stall, bus.ex_valid, bus.ex_op_a, bus.ex_op_b);
    txn++;
    nxt = next_state();
    @(posedge clk);
    m = nxt;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_valid = 1'b0;    bus.id_pc = '0;         bus.id_rs1_data = '0;
    bus.id_rs2_data = '0;   bus.id_imm = '0;        bus.id_rs1 = '0;
    bus.id_rs2 = '0;        bus.id_rd = '0;         bus.id_alu_sel = ALU_ADD;
    bus.id_use_imm = 1'b0;  bus.id_use_pc = 1'b0;   bus.id_reg_write = 1'b0;
    bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0; bus.id_branch = BR_NONE;
    hold = 1'b0; flush = 1'b0;
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
  endtask

  task automatic rand_inputs();
    bus.id_valid     = ($urandom_range(0, 9) != 0);
    bus.id_pc        = $urandom;
    bus.id_rs1_data  = $urandom;
    bus.id_rs2_data  = $urandom;
    bus.id_imm       = $urandom;
    bus.id_rs1       = RW'($urandom_range(0, 3));
    bus.id_rs2       = RW'($urandom_range(0, 3));
    bus.id_rd        = RW'($urandom_range(0, 3));
    bus.id_alu_sel   = 4'($urandom_range(0, 9));
    bus.id_use_imm   = ($urandom_range(0, 1) == 1);
    bus.id_use_pc    = ($urandom_range(0, 3) == 0);
    bus.id_reg_write = ($urandom_range(0, 3) != 0);
    bus.id_mem_read  = ($urandom_range(0, 2) == 0);
    bus.id_mem_write = ($urandom_range(0, 4) == 0);
    bus.id_branch    = 3'($urandom_range(0, 5));
    hold             = ($urandom_range(0, 99) < 12);
    flush            = ($urandom_range(0, 99) < 6);
    exmem_rd         = RW'($urandom_range(0, 3));
    exmem_reg_write  = ($urandom_range(0, 1) == 1);
    exmem_result     = $urandom;
    memwb_rd         = RW'($urandom_range(0, 3));
    memwb_reg_write  = ($urandom_range(0, 1) == 1);
    memwb_result     = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    m = empty_slot();
    idle();
    rst = 1'b1;
    #3;
    check_eq("rst_valid", 32'(bus.ex_valid), 32'h0);
    check_eq("rst_alu_sel", 32'(bus.ex_alu_sel), 32'(ALU_ADD));
    check_eq("rst_reg_write", 32'(bus.ex_reg_write), 32'h0);
    check_eq("rst_stall", 32'(bus.load_use_stall), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // EX/MEM forward, also winning over a matching MEM/WB.
    idle();
    bus.id_valid = 1'b1; bus.id_rs1 = 5'd5; bus.id_rs1_data = 32'h0;
    bus.id_rd = 5'd6; bus.id_reg_write = 1'b1;
    step();
    idle();
    exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'h10;
    step();
    memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'h20;
    step();

    // x0 is never forwarded.
    idle();
    bus.id_valid = 1'b1; exmem_rd = '0; exmem_reg_write = 1'b1; exmem_result = 32'hDEAD;
    step();
    #1;
    check_eq("x0_guard", bus.ex_op_a, 32'h0);
    step();

    // Load-use: LW x7, then ADD reading x7 as rs2.
    idle();
    bus.id_valid = 1'b1; bus.id_rs1 = 5'd1; bus.id_rd = 5'd7;
    bus.id_reg_write = 1'b1; bus.id_mem_read = 1'b1;
    step();
    idle();
    bus.id_valid = 1'b1; bus.id_rs2 = 5'd7; bus.id_rd = 5'd8;
    bus.id_reg_write = 1'b1; bus.id_rs2_data = 32'hBAD;
    #1;
    check_eq("lu_stall", 32'(bus.load_use_stall), 32'h1);
    step();
    check_eq("lu_bubble", 32'(bus.ex_valid), 32'h0);
    exmem_rd = 5'd7; exmem_reg_write = 1'b1; exmem_result = 32'h44;
    step();
    exmem_reg_write = 1'b0;
    memwb_rd = 5'd7; memwb_reg_write = 1'b1; memwb_result = 32'h77;
    step();
    bus.id_valid = 1'b0; memwb_reg_write = 1'b0;
    step();
    step();

    // Hold for three cycles, then flush while held.
    idle();
    bus.id_valid = 1'b1; bus.id_pc = 32'h200; bus.id_mem_write = 1'b1; bus.id_rs2 = 5'd2;
    step();
    idle();
    hold = 1'b1;
    bus.id_valid = 1'b1; bus.id_pc = 32'h999;
    for (int i = 0; i < 3; i++) step();
    check_eq("hold_pc", bus.ex_pc, 32'h200);
    check_eq("hold_mem_write", 32'(bus.ex_mem_write), 32'h1);
    flush = 1'b1;
    step();
    check_eq("flush_valid", 32'(bus.ex_valid), 32'h0);
    check_eq("flush_mem_write", 32'(bus.ex_mem_write), 32'h0);

    // PC / immediate operand select with forwarded store data.
    idle();
    bus.id_valid = 1'b1; bus.id_use_pc = 1'b1; bus.id_use_imm = 1'b1;
    bus.id_pc = 32'h100; bus.id_imm = 32'hFFFF_FFFC;
    bus.id_rs2 = 5'd3; bus.id_rs2_data = 32'h33;
    step();
    idle();
    exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'h5A5A;
    #1;
    check_eq("sel_op_a", bus.ex_op_a, 32'h100);
    check_eq("sel_op_b", bus.ex_op_b, 32'hFFFF_FFFC);
    step();

    // Asynchronous reset with a valid instruction in the stage.
    idle();
    bus.id_valid = 1'b1; bus.id_alu_sel = ALU_SUB; bus.id_reg_write = 1'b1; bus.id_rd = 5'd9;
    step();
    check_eq("pre_rst_valid", 32'(bus.ex_valid), 32'h1);
    idle();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(bus.ex_valid), 32'h0);
    check_eq("arst_alu_sel", 32'(bus.ex_alu_sel), 32'(ALU_ADD));
    check_eq("arst_reg_write", 32'(bus.ex_reg_write), 32'h0);
    check_eq("arst_op_a", bus.ex_op_a, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m = empty_slot();
    step();

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
